// File: rtl/seq_generator_param_if.sv
// Control and observation bundle for seq_generator_param: step/load/write
// requests in, current value, preview, toggle mask, index and wrap pulse out.
interface seq_generator_param_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 6
);
    localparam int IDXW = $clog2(DEPTH);

    logic              en;
    logic              dir;
    logic              load;
    logic [IDXW-1:0]   load_idx;
    logic              len_we;
    logic [IDXW:0]     len_in;
    logic              wr_en;
    logic [IDXW-1:0]   wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  Yt;
    logic [WIDTH-1:0]  Yt_next;
    logic [WIDTH-1:0]  tog;
    logic [IDXW-1:0]   idx;
    logic              wrap;

    modport master (
        output en, dir, load, load_idx, len_we, len_in, wr_en, wr_addr, wr_data,
        input  Yt, Yt_next, tog, idx, wrap
    );

    modport slave (
        input  en, dir, load, load_idx, len_we, len_in, wr_en, wr_addr, wr_data,
        output Yt, Yt_next, tog, idx, wrap
    );
endinterface

// File: rtl/seq_generator_param.sv
// Table-driven sequence generator: steps through a writable table of values,
// holding the current value in a bank of T flip-flops driven by Yt ^ target.
module seq_generator_param #(
    parameter int                     WIDTH = 4,
    parameter int                     DEPTH = 6,
    parameter logic [DEPTH*WIDTH-1:0] INIT  = {4'd2, 4'd7, 4'd3, 4'd5, 4'd8, 4'd0}
) (
    input logic                clock,
    input logic                reset_n,
    seq_generator_param_if.slave bus
);
    localparam int IDXW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_table [DEPTH];
    logic [IDXW:0]    r_len;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_yt;
    logic             r_wrap;

    logic [IDXW:0]    w_len_m1;
    logic             w_in_range;
    logic             w_fwd_wraps;
    logic             w_rev_wraps;
    logic [IDXW-1:0]  w_next_fwd;
    logic [IDXW-1:0]  w_next_rev;
    logic [IDXW-1:0]  w_next_idx;
    logic             w_step_wraps;
    logic [WIDTH-1:0] w_yt_next;
    logic             w_load_ok;
    logic [IDXW-1:0]  w_load_idx;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_tog;
    logic             w_len_ok;

    // An index left beyond a shortened length behaves like a wrap point in
    // both directions, so it rejoins the active window on the next step.
    always_comb begin
        w_len_m1     = r_len - (IDXW+1)'(1);
        w_in_range   = {1'b0, r_idx} < r_len;
        w_fwd_wraps  = !w_in_range || ({1'b0, r_idx} == w_len_m1);
        w_rev_wraps  = !w_in_range || (r_idx == '0);
        w_next_fwd   = w_fwd_wraps ? '0 : r_idx + IDXW'(1);
        w_next_rev   = w_rev_wraps ? w_len_m1[IDXW-1:0] : r_idx - IDXW'(1);
        w_next_idx   = bus.dir ? w_next_rev : w_next_fwd;
        w_step_wraps = bus.dir ? w_rev_wraps : w_fwd_wraps;
        w_yt_next    = r_table[w_next_idx];
        w_load_ok    = {1'b0, bus.load_idx} < r_len;
        w_load_idx   = w_load_ok ? bus.load_idx : '0;
        w_len_ok     = (bus.len_in != '0) && (bus.len_in <= (IDXW+1)'(DEPTH));

        w_target = r_yt;
        if (bus.load) begin
            w_target = r_table[w_load_idx];
        end else if (bus.en) begin
            w_target = w_yt_next;
        end
        w_tog = (bus.load || bus.en) ? (r_yt ^ w_target) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= '0;
            r_len  <= (IDXW+1)'(DEPTH);
            r_wrap <= 1'b0;
        end else begin
            if (bus.load) begin
                r_idx  <= w_load_idx;
                r_wrap <= 1'b0;
            end else if (bus.en) begin
                r_idx  <= w_next_idx;
                r_wrap <= w_step_wraps;
            end else begin
                r_wrap <= 1'b0;
            end
            if (bus.len_we && w_len_ok) begin
                r_len <= bus.len_in;
            end
        end
    end

    // Reads above see the old entry; a same-cycle write lands at this edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_table[gi] <= INIT[gi*WIDTH +: WIDTH];
                end else if (bus.wr_en && (bus.wr_addr == IDXW'(gi))) begin
                    r_table[gi] <= bus.wr_data;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_yt[gi] <= INIT[gi];
                end else if (w_tog[gi]) begin
                    r_yt[gi] <= ~r_yt[gi];
                end
            end
        end
    endgenerate

    assign bus.Yt      = r_yt;
    assign bus.Yt_next = w_yt_next;
    assign bus.tog     = w_tog;
    assign bus.idx     = r_idx;
    assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_seq_generator_param.sv
// Directed plus randomized checks of seq_generator_param against a small
// table/index model evaluated with modular arithmetic.
module tb_seq_generator_param;
    localparam int WIDTH = 4;
    localparam int DEPTH = 6;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    int m_tab [DEPTH];
    int m_len;
    int m_idx;
    int m_yt;
    int m_wrap;

    seq_generator_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    seq_generator_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tab  = '{0, 8, 5, 3, 7, 2};
        m_len  = DEPTH;
        m_idx  = 0;
        m_yt   = 0;
        m_wrap = 0;
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_idx = '0;
        bus.len_we = 1'b0; bus.len_in = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_Yt"},   32'(bus.Yt),   m_yt);
        chk({tag, "_idx"},  32'(bus.idx),  m_idx);
        chk({tag, "_wrap"}, 32'(bus.wrap), m_wrap);
    endtask

    // One clock cycle: drive, check pre-edge outputs, then advance the model.
    task automatic cyc(input bit e, input bit d, input bit l, input int li,
                       input bit lwe, input int lin,
                       input bit we, input int wa, input int wd);
        int nf, nr, nx, tgt, ni, nw, ti;
        @(negedge clock);
        bus.en = e; bus.dir = d; bus.load = l; bus.load_idx = 3'(li);
        bus.len_we = lwe; bus.len_in = 4'(lin);
        bus.wr_en = we; bus.wr_addr = 3'(wa); bus.wr_data = 4'(wd);
        #1;
        if (m_idx >= m_len) begin
            nf = 0;
            nr = m_len - 1;
        end else begin
            nf = (m_idx + 1) % m_len;
            nr = (m_idx + m_len - 1) % m_len;
        end
        nx = d ? nr : nf;
        if (l) begin
            ti  = (li < m_len) ? li : 0;
            tgt = m_tab[ti]; ni = ti; nw = 0;
        end else if (e) begin
            tgt = m_tab[nx]; ni = nx;
            nw  = d ? int'(nx == m_len - 1) : int'(nx == 0);
        end else begin
            tgt = m_yt; ni = m_idx; nw = 0;
        end
        check_state("cyc");
        chk("Yt_next", 32'(bus.Yt_next), m_tab[nx]);
        chk("tog",     32'(bus.tog),     m_yt ^ tgt);
        $display("cyc t=%0t en=%0d dir=%0d load=%0d/%0d len_we=%0d/%0d wr=%0d/%0d/%0h Yt=%0h idx=%0d wrap=%0d",
                 $time, e, d, l, li, lwe, lin, we, wa, wd, bus.Yt, bus.idx, bus.wrap);
        @(posedge clock);
        m_yt = tgt; m_idx = ni; m_wrap = nw;
        if (we && wa < DEPTH) m_tab[wa] = wd;
        if (lwe && lin >= 1 && lin <= DEPTH) m_len = lin;
    endtask

    task automatic full_reset();
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #2;
        check_state("rst");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Asynchronous pulse between edges; state must clear without a clock edge.
    task automatic reset_pulse();
        @(negedge clock);
        idle_inputs();
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check_state("pulse");
        #1 reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        idle_inputs();
        model_reset();

        // Forward pass over the default table with a wrap back to 0.
        full_reset();
        repeat (7) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reverse pass: first edge wraps to the last entry.
        full_reset();
        repeat (6) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Load has priority over en; idle holds; out-of-range load goes to 0.
        cyc(1, 0, 1, 3, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Shorten length while sitting beyond it, then reject illegal lengths.
        cyc(0, 0, 1, 4, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 9, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 6, 0, 0, 0);

        // Write racing a step reads old data; new value shows next pass.
        full_reset();
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 15);
        cyc(0, 0, 0, 0, 0, 0, 1, 6, 9);
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 9);
        repeat (6) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-sequence async reset restores the default table.
        reset_pulse();
        repeat (7) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional async reset pulses.
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) reset_pulse();
            cyc(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 8) == 0,
                int'($urandom % 8), ($urandom % 10) == 0, int'($urandom % 16),
                ($urandom % 5) == 0, int'($urandom % 8), int'($urandom % 16));
        end
        @(negedge clock);
        idle_inputs();
        #1;
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
